// File: rtl/pp_final_adder_pipe.sv
// -----------------------------------------------------------------------------
// pp_final_adder_pipe
//
// Carry-propagate adder that follows the signed 8x8 Wallace-tree compressor.
// It adds the redundant sum and carry rows into the final two's-complement
// product, modulo 2^WIDTH. The add is split into two registered halves so that
// no cycle contains more than one half-width add:
//   stage 1 : low LO_W bits are added; the carry-out and both high halves are
//             registered.
//   stage 2 : high halves plus the registered carry form the upper result bits.
// Both sides use a valid/ready handshake. A slot is refilled in the same cycle
// that it drains, so the pipe sustains one result per cycle.
//
// Optional build macro: PP_FINAL_ADDER_ZERO_FLAG_EN
//   When defined, the block adds a registered prod_zero output. It is set when
//   the whole result is zero and it moves and holds together with prod.
// -----------------------------------------------------------------------------
module pp_final_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int LO_W  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pp0,
    input  logic [WIDTH-1:0] pp1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
    ,
    output logic             prod_zero
`endif
);

    localparam int HI_W = WIDTH - LO_W;

    // Stage 1 registers: low-half sum, its carry-out, and both high halves.
    logic             s1_valid_q, s1_valid_d;
    logic             c1_q,       c1_d;
    logic [LO_W-1:0]  lo_q,       lo_d;
    logic [HI_W-1:0]  hi0_q,      hi0_d;
    logic [HI_W-1:0]  hi1_q,      hi1_d;

    // Stage 2 registers: the finished product.
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] prod_q,     prod_d;
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
    logic             zero_q,     zero_d;
`endif

    // Handshake and datapath intermediates.
    logic             adv1;
    logic             adv2;
    logic             accept;
    logic [LO_W:0]    lo_sum;
    logic [HI_W-1:0]  hi_sum;

    // Stall control: a stage may move when its successor is empty or moving.
    // in_ready depends only on state, out_ready and rstn, never on in_valid.
    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1 && rstn;
        accept   = in_valid && in_ready;
    end

    // Half-width adders: low half with carry-out, high half with carry-in.
    // The high-half carry-out falls off the end, giving the modulo-2^WIDTH sum.
    always_comb begin
        lo_sum = {1'b0, pp0[LO_W-1:0]} + {1'b0, pp1[LO_W-1:0]};
        hi_sum = hi0_q + hi1_q + HI_W'(c1_q);
    end

    // Stage 1 next state: valid follows the input when the stage moves;
    // data loads only on an actual accept so it is never overwritten by junk.
    always_comb begin
        // NOTE: every variable gets a hold-value default first, so no path
        // through this block leaves an output unassigned and no latch is inferred.
        s1_valid_d = s1_valid_q;
        c1_d       = c1_q;
        lo_d       = lo_q;
        hi0_d      = hi0_q;
        hi1_d      = hi1_q;
        if (adv1) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            {c1_d, lo_d} = lo_sum;
            hi0_d        = pp0[WIDTH-1:LO_W];
            hi1_d        = pp1[WIDTH-1:LO_W];
        end
    end

    // Stage 2 next state: when the output slot moves it takes stage 1's
    // contents, or becomes a bubble if stage 1 is empty; data holds otherwise.
    always_comb begin
        s2_valid_d = s2_valid_q;
        prod_d     = prod_q;
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
        zero_d     = zero_q;
`endif
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                prod_d = {hi_sum, lo_q};
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
                zero_d = (hi_sum == '0) && (lo_q == '0);
`endif
            end
        end
    end

    // Pipeline registers with synchronous active-low reset that empties both
    // stages and clears all data, discarding anything in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the
        // pre-edge values, so the two stages shift together without ordering races.
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            c1_q       <= 1'b0;
            lo_q       <= '0;
            hi0_q      <= '0;
            hi1_q      <= '0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            c1_q       <= c1_d;
            lo_q       <= lo_d;
            hi0_q      <= hi0_d;
            hi1_q      <= hi1_d;
            s2_valid_q <= s2_valid_d;
            prod_q     <= prod_d;
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
            zero_q     <= zero_d;
`endif
        end
    end

    // Outputs come straight from stage 2 registers.
    always_comb begin
        out_valid = s2_valid_q;
        prod      = prod_q;
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
        prod_zero = zero_q;
`endif
    end

endmodule

// File: tb/tb_pp_final_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_pp_final_adder_pipe
//
// Scoreboard bench. The driver pushes (pp0 + pp1) mod 2^W for every accepted
// pair; a monitor pops and compares on every output transfer and checks that
// a stalled output holds steady. Directed cases cover the carry across halves,
// signed corners, wrap, streaming, backpressure and reset mid-flight; a random
// phase follows with random gaps and random backpressure.
// Honours PP_FINAL_ADDER_ZERO_FLAG_EN for the optional prod_zero port.
// -----------------------------------------------------------------------------
module tb_pp_final_adder_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] pp0;
    logic [W-1:0] pp1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] prod;
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
    logic         prod_zero;
`endif

    pp_final_adder_pipe #(.WIDTH(W), .LO_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp0       (pp0),
        .pp1       (pp1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
        ,
        .prod_zero (prod_zero)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_out = 0;
    bit           hold_pending = 1'b0;
    logic [W-1:0] held_prod;
    bit           rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: the product is simply the integer sum of both rows, mod 2^W.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pair and hold it until accepted or the budget runs out.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int budget, output int waited);
        bit done;
        done     = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        pp0      = a;
        pp1      = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b));
                done = 1'b1;
            end
            tick();
            if (!done) begin
                waited++;
                if (waited > budget) begin
                    fail("send_timeout");
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n <= budget) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare each transferred result against the scoreboard, and
    // require that a stalled output keeps its value across the edge.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rstn && hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_prod", 32'(prod), 32'(held_prod));
        end
        if (rstn && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                fail("unexpected_output");
            end else begin
                e = exp_q.pop_front();
                check("prod", 32'(prod), 32'(e));
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
                check("prod_zero", 32'(prod_zero), 32'(e == '0));
`endif
            end
        end
        hold_pending = rstn && out_valid && !out_ready;
        held_prod    = prod;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int total_wait;
        int stale;

        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp0       = '0;
        pp1       = '0;

        // Reset state.
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_prod", 32'(prod), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef PP_FINAL_ADDER_ZERO_FLAG_EN
        check("rst_prod_zero", 32'(prod_zero), 32'd0);
`endif
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        tick();

        // Carry across the halves, with latency and single-cycle output.
        out_ready = 1'b1;
        send(16'h00FF, 16'h0001, 10, waited);
        @(negedge clk);
        check("lat_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_prod", 32'(prod), 32'h0100);
        @(negedge clk);
        check("lat_one_cycle", 32'(out_valid), 32'd0);
        tick();

        // Signed corners and wrap.
        send(16'h3FFF, 16'h0001, 10, waited);
        send(16'hFF80, 16'h0000, 10, waited);
        send(16'hFFFF, 16'h0001, 10, waited);
        wait_drain("corners_drain", 10);

        // Streaming: 8 back-to-back pairs, no stalls, full throughput.
        total_wait = 0;
        for (int i = 0; i < 8; i++) begin
            send(W'(i), W'(16'h0100 * i), 10, waited);
            total_wait += waited;
        end
        check("stream_no_stall", 32'(total_wait), 32'd0);
        wait_drain("stream_drain", 3);

        // Backpressure: two accepts fill the pipe, the third waits.
        out_ready = 1'b0;
        send(16'h1234, 16'h0F0F, 10, waited);
        send(16'h8000, 16'h8001, 10, waited);
        in_valid = 1'b1;
        pp0      = 16'h00AA;
        pp1      = 16'h0055;
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_prod_first", 32'(prod), 32'(model(16'h1234, 16'h0F0F)));
        tick();
        @(negedge clk);
        check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_fill_on_drain", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back(model(16'h00AA, 16'h0055));
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
        tick();

        // Reset with two results in flight.
        send(16'h1111, 16'h2222, 10, waited);
        send(16'h3333, 16'h4444, 10, waited);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rstn = 1'b1;
        exp_q.delete();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_prod", 32'(prod), 32'd0);
        out_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("midrst_no_stale", 32'(stale), 32'd0);
        tick();

        // Random traffic with random gaps and random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(W'($urandom), W'($urandom), 100, waited);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("random_drain", 20);
        check("outputs_seen", 32'(n_out >= 314), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
